alt_pfl_crc_ctrl: RTL and testbench

Frame-level sequencer for the PFL byte-wise CRC-16 engine. It accepts a frame of N bytes over a valid/ready stream, clears the engine and feeds it one byte per accepted beat. It then reads the 16-bit result out through the engine's serial shift port, rotating so the engine contents are preserved. Finally it reports the CRC and a match flag against an expected value. It sits between the flash-read/config datapath (byte producer) and the CRC engine instance.

---
 rtl/alt_pfl_crc_ctrl.sv | 139 +++++++++++++
 tb/tb_alt_pfl_crc_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alt_pfl_crc_ctrl.sv
// alt_pfl_crc_ctrl: frame sequencer for the byte-wise CRC-16 engine.
// Clears the engine, streams N bytes into it, then rotates the 16-bit result
// out through the serial port (engine contents preserved) and reports it.
module alt_pfl_crc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [15:0]      expected_crc,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             crc_clr,
    output logic             crc_ena,
    output logic [7:0]       crc_d,
    output logic             crc_shiftenable,
    output logic             crc_shiftin,
    input  logic             crc_shiftout,
    output logic             busy,
    output logic             done,
    output logic [15:0]      crc_value,
    output logic             crc_match
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_DATA, S_SHIFT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [15:0]      exp_q, exp_d;
    logic [15:0]      cap_q, cap_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      crc_value_q, crc_value_d;
    logic             crc_match_q, crc_match_d;
    logic             crc_clr_q, crc_clr_d;
    logic             shen_q, shen_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Byte handshake is combinational; abort (and reset) refuse the beat.
    always_comb begin
        din_ready   = (state_q == S_DATA) && !abort && !clr;
        crc_ena     = din_ready && din_valid;
        crc_d       = din;
        // Feed the engine's own output back in so 16 shifts restore it.
        crc_shiftin = shen_q && crc_shiftout;
    end

    // Next-state, counters and result capture.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        exp_d       = exp_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        crc_value_d = crc_value_q;
        crc_match_d = crc_match_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    rem_d   = byte_count;
                    exp_d   = expected_crc;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = (rem_q != '0) ? S_DATA : S_SHIFT;
            S_DATA: begin
                if (crc_ena) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Engine bit 0 comes out first; shifting in from the top
                // leaves cap equal to the engine register after 16 shifts.
                cap_d = {crc_shiftout, cap_q[15:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        // Publish the result on entry to DONE so it is visible with done.
        if (state_q == S_SHIFT && state_d == S_DONE) begin
            crc_value_d = cap_d;
            crc_match_d = (cap_d == exp_q);
        end
        // Strobes are decoded from the next state so they are flop outputs.
        crc_clr_d = (state_d == S_CLEAR);
        shen_d    = (state_d == S_SHIFT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            exp_q       <= '0;
            cap_q       <= '0;
            cnt_q       <= '0;
            crc_value_q <= '0;
            crc_match_q <= 1'b0;
            crc_clr_q   <= 1'b0;
            shen_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            exp_q       <= exp_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            crc_value_q <= crc_value_d;
            crc_match_q <= crc_match_d;
            crc_clr_q   <= crc_clr_d;
            shen_q      <= shen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign crc_clr         = crc_clr_q;
    assign crc_shiftenable = shen_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign crc_value       = crc_value_q;
    assign crc_match       = crc_match_q;

endmodule

// File: tb/tb_alt_pfl_crc_ctrl.sv
// tb_alt_pfl_crc_ctrl: directed and randomized frames against a CRC-16 engine
// model and a frame-level reference (CRC of the byte string, cycle schedule).
module tb_alt_pfl_crc_ctrl;

    logic        clk = 1'b0;
    logic        clr, start, abort, din_valid;
    logic [15:0] byte_count, expected_crc;
    logic [7:0]  din;
    logic        din_ready, crc_clr, crc_ena, crc_shiftenable, crc_shiftin, crc_shiftout;
    logic [7:0]  crc_d;
    logic        busy, done, crc_match;
    logic [15:0] crc_value;

    alt_pfl_crc_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .byte_count(byte_count), .expected_crc(expected_crc),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .crc_clr(crc_clr), .crc_ena(crc_ena), .crc_d(crc_d),
        .crc_shiftenable(crc_shiftenable), .crc_shiftin(crc_shiftin),
        .crc_shiftout(crc_shiftout), .busy(busy), .done(done),
        .crc_value(crc_value), .crc_match(crc_match)
    );

    always #5 clk = ~clk;

    // CRC-16/CCITT byte update (poly 0x1021, MSB first).
    function automatic logic [15:0] upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Engine model: clear to 0, absorb bytes, rotate right on shift.
    logic [15:0] eng = 16'hBEEF;
    assign crc_shiftout = eng[0];
    always @(posedge clk) begin
        if (crc_clr)              eng <= 16'h0000;
        else if (crc_ena)         eng <= upd(eng, crc_d);
        else if (crc_shiftenable) eng <= {crc_shiftin, eng[15:1]};
    end

    logic [7:0]  fb [256];
    int          vectors = 0, miscompares = 0;
    logic [15:0] last_val = 16'h0000;

    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c = 16'h0000;
        for (int i = 0; i < n; i++) c = upd(c, fb[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One frame. vmode: 0 continuous valid, 1 toggling 1/0, 2 random.
    // abort_at > 0 raises abort in that cycle; stray_at raises a start with
    // a different byte_count while busy.
    task automatic run_frame(input string nm, input int n, input logic [15:0] exp,
                             input int vmode, input int abort_at, input int stray_at);
        int c, idx, bub, nena, nsh, first_sh, done_c;
        bit tog, fin;
        logic [15:0] want;
        idx = 0; bub = 0; nena = 0; nsh = 0; first_sh = -1; done_c = -1;
        tog = 1'b1; fin = 1'b0;
        want = ref_crc(n);
        @(negedge clk);
        start = 1'b1; byte_count = n[15:0]; expected_crc = exp;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (!fin) begin
            din   = fb[idx];
            abort = (c == abort_at);
            start = (c == stray_at);
            byte_count = (c == stray_at) ? 16'd50 : n[15:0];
            case (vmode)
                0:       din_valid = 1'b1;
                1:       din_valid = tog;
                default: din_valid = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            chk({nm, " excl"}, 32'($onehot0({crc_ena, crc_shiftenable, crc_clr})), 32'd1);
            chk({nm, " busy"}, 32'(busy), 32'd1);
            if (c == 1) begin
                chk({nm, " clr_pulse"}, 32'(crc_clr), 32'd1);
                chk({nm, " value_held"}, 32'(crc_value), 32'(last_val));
            end
            if (din_ready) begin
                if (!din_valid) bub++;
                tog = ~tog;
            end
            if (crc_ena) begin
                chk({nm, " crc_d"}, 32'(crc_d), 32'(fb[idx]));
                nena++; idx++;
            end
            if (crc_shiftenable) begin
                nsh++;
                if (first_sh < 0) first_sh = c;
            end
            if (done) begin done_c = c; fin = 1'b1; end
            if (abort_at > 0 && c == abort_at) fin = 1'b1;
            if (c > 600) begin
                vectors++; miscompares++;
                $error("FAIL %s timeout: observed no done expected done by cycle %0d", nm, n + 18 + bub);
                fin = 1'b1;
            end
            if (!fin) begin @(posedge clk); #1; c++; end
        end
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        chk({nm, " busy_after"}, 32'(busy), 32'd0);
        chk({nm, " done_after"}, 32'(done), 32'd0);
        chk({nm, " first_shift"}, 32'(first_sh), 32'(n + 2 + bub));
        if (abort_at > 0) begin
            chk({nm, " no_done"}, 32'(done_c), 32'hFFFF_FFFF);
            chk({nm, " value_kept"}, 32'(crc_value), 32'(last_val));
        end else begin
            chk({nm, " done_cycle"}, 32'(done_c), 32'(n + 18 + bub));
            chk({nm, " shift_cnt"}, 32'(nsh), 32'd16);
            chk({nm, " ena_cnt"}, 32'(nena), 32'(n));
            chk({nm, " crc_value"}, 32'(crc_value), 32'(want));
            chk({nm, " crc_match"}, 32'(crc_match), 32'(want == exp));
            chk({nm, " engine_kept"}, 32'(eng), 32'(want));
            last_val = want;
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 8'h00;
        byte_count = 16'h0; expected_crc = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);            chk("rst done", 32'(done), 0);
        chk("rst din_ready", 32'(din_ready), 0);  chk("rst crc_clr", 32'(crc_clr), 0);
        chk("rst crc_ena", 32'(crc_ena), 0);      chk("rst shen", 32'(crc_shiftenable), 0);
        chk("rst shiftin", 32'(crc_shiftin), 0);  chk("rst value", 32'(crc_value), 0);
        chk("rst match", 32'(crc_match), 0);
        @(posedge clk); #1 clr = 1'b0;

        run_frame("zero_len", 0, 16'h0000, 0, -1, -1);

        for (int i = 0; i < 4; i++) fb[i] = 8'h00;
        run_frame("zeros4", 4, 16'h1234, 0, -1, -1);

        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        run_frame("ascii9", 9, ref_crc(9), 1, -1, -1);

        // Reset mid-DATA with three bytes left.
        for (int i = 0; i < 6; i++) fb[i] = 8'($urandom);
        @(negedge clk);
        start = 1'b1; byte_count = 16'd6; expected_crc = 16'h0;
        @(posedge clk); #1;
        start = 1'b0; din_valid = 1'b1; din = fb[0];
        repeat (4) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        chk("clr busy", 32'(busy), 0);            chk("clr done", 32'(done), 0);
        chk("clr din_ready", 32'(din_ready), 0);  chk("clr crc_clr", 32'(crc_clr), 0);
        chk("clr shen", 32'(crc_shiftenable), 0); chk("clr shiftin", 32'(crc_shiftin), 0);
        chk("clr value", 32'(crc_value), 0);      chk("clr match", 32'(crc_match), 0);
        last_val = 16'h0000;
        run_frame("post_clr", 6, 16'hFFFF, 0, -1, -1);

        // Abort at SHIFT counter 5 (cycle 2+2+5); stray start in DATA.
        fb[0] = 8'hA5; fb[1] = 8'h5A;
        run_frame("abort", 2, 16'h5555, 0, 9, 2);

        for (int k = 0; k < 6; k++) begin
            int n;
            logic [15:0] e;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
            e = (k % 2 == 1) ? ref_crc(n) : 16'($urandom);
            run_frame("random", n, e, 2, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
